// File: rtl/hopfield_current_engine_if.sv
// Bus bundle between the weight store / control side and the serial current engine.
// The master drives the request, the latched operands and the live weight matrix;
// the slave (the engine) returns the current vector together with its status flags.
interface hopfield_current_engine_if #(
   parameter int N  = 7,
   parameter int WW = 16,
   parameter int CW = 32,
   parameter int P  = 4
);
   logic                start;
   logic                learning_enable;
   logic [P-1:0]        pattern_input;
   logic [N-1:0]        spikes_in;
   logic [N*N*WW-1:0]   weights_flat;
   logic [N*CW-1:0]     currents_flat;
   logic                busy;
   logic                valid;

   modport master (
      output start, learning_enable, pattern_input, spikes_in, weights_flat,
      input  currents_flat, busy, valid
   );

   modport slave (
      input  start, learning_enable, pattern_input, spikes_in, weights_flat,
      output currents_flat, busy, valid
   );
endinterface

// File: rtl/hopfield_current_engine.sv
// Time-multiplexed synaptic current engine for the spiking Hopfield network.
// One (target, source) synapse is folded into a saturating accumulator per clock,
// row-major, so a full evaluation takes N*N accumulate cycles plus one publish cycle.
// Finished rows are parked in a shadow array and all currents are published together.
module hopfield_current_engine #(
   parameter int N           = 7,
   parameter int WW          = 16,
   parameter int CW          = 32,
   parameter int P           = 4,
   parameter int SPIKE_SCALE = 256,
   parameter int EXT_CURRENT = 131072,
   parameter int ALLOW_SELF  = 0
) (
   input logic                       clk_i,
   input logic                       reset_n_i,
   hopfield_current_engine_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = (N > 1) ? $clog2(N * N) : 1;
   localparam logic [IW-1:0]        LAST_IDX = IW'(N - 1);
   localparam logic signed [CW-1:0] MAX_CUR  = {1'b0, {(CW-1){1'b1}}};
   localparam logic signed [CW-1:0] MIN_CUR  = {1'b1, {(CW-1){1'b0}}};
   localparam logic signed [CW-1:0] SCALE_CW = CW'(SPIKE_SCALE);
   localparam logic signed [CW-1:0] EXT_CW   = CW'(EXT_CURRENT);

   state_e               state_q, state_d;
   logic [IW-1:0]        rowIdx_q, colIdx_q;
   logic signed [CW-1:0] acc_q;
   logic signed [CW-1:0] shadow_q [N];
   logic [N*CW-1:0]      currents_q;
   logic                 valid_q;
   logic [N-1:0]         spikesLat_q;
   logic [P-1:0]         patternLat_q;
   logic                 learnLat_q;

   logic                 accepting;
   logic                 accumulating;
   logic                 loadOutputs;
   logic                 lastCol;
   logic                 lastSynapse;
   logic [SW-1:0]        flatIdx;
   logic [WW-1:0]        wMat [N*N];
   logic signed [CW-1:0] weightExt;
   logic signed [CW-1:0] synTerm;
   logic signed [CW-1:0] accSyn;
   logic signed [CW-1:0] accFinal;
   logic [N-1:0]         patternExt;
   logic                 selfSkip;
   logic                 injectExt;

   // Adds in CW+1 bits and pins the result to the representable range on overflow.
   function automatic logic signed [CW-1:0] satAdd(input logic signed [CW-1:0] a,
                                                   input logic signed [CW-1:0] b);
      logic signed [CW:0] sum;
      sum = {a[CW-1], a} + {b[CW-1], b};
      if (sum[CW] != sum[CW-1]) begin
         return sum[CW] ? MIN_CUR : MAX_CUR;
      end
      return sum[CW-1:0];
   endfunction

   // Unpack the flat weight bus into an indexable matrix view.
   for (genvar k = 0; k < N * N; k++) begin : g_wmat
      assign wMat[k] = bus.weights_flat[k*WW +: WW];
   end

   // State register; reset abandons any run in progress.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a start is only honoured while idle, later starts are dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = ACC;
         ACC:     if (lastSynapse) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode of the current state.
   always_comb begin
      accepting    = 1'b0;
      accumulating = 1'b0;
      loadOutputs  = 1'b0;
      case (state_q)
         IDLE:    accepting    = bus.start;
         ACC:     accumulating = 1'b1;
         DONE:    loadOutputs  = 1'b1;
         default: ;
      endcase
   end

   // Synapse term for the current (row, col) pair, plus the end-of-row pattern injection.
   always_comb begin
      lastCol     = (colIdx_q == LAST_IDX);
      lastSynapse = lastCol && (rowIdx_q == LAST_IDX);
      flatIdx     = SW'(int'(rowIdx_q) * N + int'(colIdx_q));
      weightExt   = CW'($signed(wMat[flatIdx]));
      selfSkip    = (ALLOW_SELF == 0) && (rowIdx_q == colIdx_q);
      synTerm     = (spikesLat_q[colIdx_q] && !selfSkip) ? (weightExt * SCALE_CW) : '0;
      accSyn      = satAdd(acc_q, synTerm);
      patternExt  = N'(patternLat_q);
      injectExt   = learnLat_q && patternExt[rowIdx_q];
      accFinal    = (lastCol && injectExt) ? satAdd(accSyn, EXT_CW) : accSyn;
   end

   // Operand latching, row/column walk, accumulator and per-row shadow write-back.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         acc_q        <= '0;
         rowIdx_q     <= '0;
         colIdx_q     <= '0;
         spikesLat_q  <= '0;
         patternLat_q <= '0;
         learnLat_q   <= 1'b0;
         for (int k = 0; k < N; k++) begin
            shadow_q[k] <= '0;
         end
      end else if (accepting) begin
         spikesLat_q  <= bus.spikes_in;
         patternLat_q <= bus.pattern_input;
         learnLat_q   <= bus.learning_enable;
         rowIdx_q     <= '0;
         colIdx_q     <= '0;
         acc_q        <= '0;
      end else if (accumulating) begin
         if (lastCol) begin
            shadow_q[rowIdx_q] <= accFinal;
            acc_q              <= '0;
            colIdx_q           <= '0;
            rowIdx_q           <= (rowIdx_q == LAST_IDX) ? '0 : rowIdx_q + 1'b1;
         end else begin
            acc_q    <= accSyn;
            colIdx_q <= colIdx_q + 1'b1;
         end
      end
   end

   // Publish all shadow currents on one edge and pulse valid alongside them.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         currents_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= loadOutputs;
         if (loadOutputs) begin
            for (int k = 0; k < N; k++) begin
               currents_q[k*CW +: CW] <= shadow_q[k];
            end
         end
      end
   end

   assign bus.currents_flat = currents_q;
   assign bus.valid         = valid_q;
   assign bus.busy          = accumulating;

endmodule
